// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-port RAM access controller for a 32-bit core.
// Takes byte/halfword/word loads and stores and turns them into RAM word
// reads/writes. Sub-word stores use a read-modify-write sequence, and
// misaligned or illegal-size requests are rejected without touching the RAM.
module mem_access_ctrl #(
  parameter int unsigned LARGO = 1024,
  parameter int unsigned ANCHO = 32,
  localparam int unsigned AW = $clog2(LARGO)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [31:0]      req_addr,
  input  logic [ANCHO-1:0] req_wdata,
  output logic             req_ready,
  output logic             resp_valid,
  output logic [ANCHO-1:0] resp_rdata,
  output logic             resp_err,
  output logic             ram_we,
  output logic             ram_re,
  output logic [AW-1:0]    ram_addr,
  output logic [ANCHO-1:0] ram_din,
  input  logic [ANCHO-1:0] ram_dout
);

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StRmwRd,
    StWr,
    StResp,
    StErr
  } state_e;

  state_e      state_q;
  logic [1:0]  addr_lo_q;
  logic [1:0]  size_q;
  logic        uns_q;
  // Only the low halfword is needed after accept; word stores use req_wdata directly.
  logic [15:0] wdata_q;

  logic             req_err;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;
  logic [ANCHO-1:0] load_data;
  logic [ANCHO-1:0] merged_data;

  // Address bits above the word index wrap away.
  logic unused_addr;
  assign unused_addr = ^req_addr[31:AW+2];

  // Ready is combinational so it drops with RESET and returns right after release.
  assign req_ready = (state_q == StIdle) && !RESET;

  // Detect illegal size or misaligned address on the incoming request.
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = (req_addr[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
  end

  // Extract the addressed lane from the RAM word and extend it for loads.
  always_comb begin
    lane_b    = ram_dout[{addr_lo_q, 3'b000} +: 8];
    lane_h    = ram_dout[{addr_lo_q[1], 4'b0000} +: 16];
    load_data = ram_dout;
    case (size_q)
      2'b00:   load_data = uns_q ? {{(ANCHO-8){1'b0}}, lane_b}
                                 : {{(ANCHO-8){lane_b[7]}}, lane_b};
      2'b01:   load_data = uns_q ? {{(ANCHO-16){1'b0}}, lane_h}
                                 : {{(ANCHO-16){lane_h[15]}}, lane_h};
      default: load_data = ram_dout;
    endcase
  end

  // Replace only the target lane(s) of the fetched word for sub-word stores.
  always_comb begin
    merged_data = ram_dout;
    case (size_q)
      2'b00:   merged_data[{addr_lo_q, 3'b000} +: 8]    = wdata_q[7:0];
      2'b01:   merged_data[{addr_lo_q[1], 4'b0000} +: 16] = wdata_q;
      default: merged_data = ram_dout;
    endcase
  end

  // Control FSM; every output is set on the edge entering the state that owns it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= StIdle;
      addr_lo_q  <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      ram_we     <= 1'b0;
      ram_re     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            ram_addr  <= req_addr[AW+1:2];
            addr_lo_q <= req_addr[1:0];
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            wdata_q   <= req_wdata[15:0];
            if (req_err) begin
              state_q    <= StErr;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (!req_write) begin
              state_q <= StRd;
              ram_re  <= 1'b1;
            end else if (req_size == 2'b10) begin
              state_q <= StWr;
              ram_we  <= 1'b1;
              ram_din <= req_wdata;
            end else begin
              state_q <= StRmwRd;
              ram_re  <= 1'b1;
            end
          end
        end
        StRd: begin
          state_q    <= StResp;
          ram_re     <= 1'b0;
          resp_valid <= 1'b1;
          resp_rdata <= load_data;
        end
        StRmwRd: begin
          state_q <= StWr;
          ram_re  <= 1'b0;
          ram_we  <= 1'b1;
          ram_din <= merged_data;
        end
        StWr: begin
          state_q    <= StResp;
          ram_we     <= 1'b0;
          ram_din    <= '0;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
        end
        StResp, StErr: begin
          state_q    <= StIdle;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: directed scenarios plus randomized traffic
// checked against a byte-lane arithmetic reference model of the RAM.
module tb_mem_access_ctrl;

  localparam int unsigned LARGO = 1024;
  localparam int unsigned AW = 10;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          req_valid, req_write, req_unsigned;
  logic [1:0]    req_size;
  logic [31:0]   req_addr, req_wdata;
  logic          req_ready, resp_valid, resp_err, ram_we, ram_re;
  logic [31:0]   resp_rdata, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;

  logic [31:0] mem     [LARGO];
  logic [31:0] ref_mem [LARGO];

  int errors = 0;
  int checks = 0;

  mem_access_ctrl #(.LARGO(LARGO), .ANCHO(32)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .ram_we       (ram_we),
    .ram_re       (ram_re),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout)
  );

  always #5 CLK = ~CLK;

  // Attached RAM: asynchronous read gated by ram_re, synchronous write.
  assign ram_dout = ram_re ? mem[ram_addr] : 32'h0;
  always @(posedge CLK) if (ram_we) mem[ram_addr] <= ram_din;

  // Reference: whole-word arithmetic on ref_mem using byte masks and shifts.
  function automatic void ref_access(input logic wr, input logic [1:0] sz, input logic uns,
                                     input logic [31:0] addr, input logic [31:0] wd,
                                     output logic err, output logic [31:0] rd, output int lat);
    int nbytes, idx, shift;
    logic [31:0] mask, word, val;
    nbytes = 1 << sz;
    err = (sz == 2'd3) || ((addr % nbytes) != 0);
    rd = 32'h0;
    lat = 1;
    if (err) return;
    idx   = (addr / 4) % LARGO;
    shift = (addr % 4) * 8;
    mask  = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
    word  = ref_mem[idx];
    if (!wr) begin
      val = (word >> shift) & mask;
      if (!uns && nbytes < 4 && val[8*nbytes-1]) val = val | ~mask;
      rd  = val;
      lat = 2;
    end else begin
      ref_mem[idx] = (word & ~(mask << shift)) | ((wd & mask) << shift);
      lat = (nbytes == 4) ? 2 : 3;
    end
  endfunction

  // Issue one request and observe the transaction cycle by cycle (cycle 1 = after accept).
  task automatic run_req(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic err,
                         output int re_at, output int we_at, output logic [31:0] din_at_we,
                         output logic [AW-1:0] addr_at_re, output int viol);
    int w;
    lat = 0; rd = 32'h0; err = 1'b0; re_at = 0; we_at = 0; din_at_we = 32'h0;
    addr_at_re = '0; viol = 0; w = 0;
    while (!req_ready && w < 20) begin
      @(negedge CLK);
      w++;
    end
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      if (ram_re && ram_we) viol++;
      if (!ram_we && ram_din != 32'h0) viol++;
      if (!resp_valid && (resp_rdata != 32'h0 || resp_err)) viol++;
      if (ram_re && re_at == 0) begin re_at = c; addr_at_re = ram_addr; end
      if (ram_we && we_at == 0) begin we_at = c; din_at_we = ram_din; end
      if (resp_valid) begin
        lat = c; rd = resp_rdata; err = resp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(negedge CLK);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b want 0", req_ready);
    end
    checks++;
    if ({resp_valid, resp_err, ram_we, ram_re} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000", {resp_valid, resp_err, ram_we, ram_re});
    end
    checks++;
    if (resp_rdata !== 32'h0 || ram_din !== 32'h0 || ram_addr !== '0) begin
      errors++; $display("FAIL reset_data: got rdata=%h din=%h addr=%h want all 0",
                         resp_rdata, ram_din, ram_addr);
    end
    RESET = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b want 1", req_ready);
    end
    @(negedge CLK);
  endtask

  task automatic test_load_word();
    int lat, re_at, we_at, viol; logic [31:0] rd, din, er; logic err, eerr; int elat;
    logic [AW-1:0] ra;
    mem[5] = 32'h1122_3344; ref_mem[5] = 32'h1122_3344;
    ref_access(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, eerr, er, elat);
    run_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, lat, rd, err, re_at, we_at, din, ra, viol);
    checks++;
    if (lat !== 2 || rd !== 32'h1122_3344 || err !== 1'b0) begin
      errors++; $display("FAIL load_word: got lat=%0d rdata=%h err=%b want lat=2 rdata=11223344 err=0",
                         lat, rd, err);
    end
    checks++;
    if (re_at !== 1 || we_at !== 0) begin
      errors++; $display("FAIL load_word_ram: got re_at=%0d we_at=%0d want 1,0", re_at, we_at);
    end
  endtask

  task automatic test_load_sub();
    logic [31:0] pre [3] = '{32'h1122_3344, 32'h1122_3344, 32'h80FF_0000};
    logic [31:0] adr [3] = '{32'h17, 32'h16, 32'h16};
    logic [1:0]  sz  [3] = '{2'b00, 2'b01, 2'b00};
    logic        un  [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] exp [3] = '{32'h0000_0011, 32'h0000_1122, 32'hFFFF_FFFF};
    int lat, re_at, we_at, viol; logic [31:0] rd, din; logic err; logic [AW-1:0] ra;
    for (int i = 0; i < 3; i++) begin
      mem[5] = pre[i]; ref_mem[5] = pre[i];
      run_req(1'b0, sz[i], un[i], adr[i], 32'h0, lat, rd, err, re_at, we_at, din, ra, viol);
      checks++;
      if (lat !== 2 || rd !== exp[i] || err !== 1'b0) begin
        errors++; $display("FAIL load_sub[%0d]: got lat=%0d rdata=%h err=%b want lat=2 rdata=%h err=0",
                           i, lat, rd, err, exp[i]);
      end
    end
  endtask

  task automatic test_rmw_store();
    int lat, re_at, we_at, viol, elat; logic [31:0] rd, din, er; logic err, eerr;
    logic [AW-1:0] ra;
    mem[2] = 32'hAABB_CCDD; ref_mem[2] = 32'hAABB_CCDD;
    ref_access(1'b1, 2'b00, 1'b0, 32'h09, 32'h55, eerr, er, elat);
    run_req(1'b1, 2'b00, 1'b0, 32'h09, 32'h0000_0055, lat, rd, err, re_at, we_at, din, ra, viol);
    checks++;
    if (re_at !== 1 || we_at !== 2 || din !== 32'hAABB_55DD) begin
      errors++; $display("FAIL rmw_ram: got re_at=%0d we_at=%0d din=%h want 1,2,aabb55dd",
                         re_at, we_at, din);
    end
    checks++;
    if (lat !== 3 || err !== 1'b0 || rd !== 32'h0) begin
      errors++; $display("FAIL rmw_resp: got lat=%0d err=%b rdata=%h want 3,0,0", lat, err, rd);
    end
    run_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, lat, rd, err, re_at, we_at, din, ra, viol);
    checks++;
    if (rd !== 32'hAABB_55DD || lat !== 2) begin
      errors++; $display("FAIL rmw_readback: got rdata=%h lat=%0d want aabb55dd,2", rd, lat);
    end
  endtask

  task automatic test_errors();
    logic [31:0] adr [2] = '{32'h03, 32'h06};
    logic        wr  [2] = '{1'b1, 1'b0};
    logic [1:0]  sz  [2] = '{2'b01, 2'b10};
    int lat, re_at, we_at, viol; logic [31:0] rd, din, m0, m1; logic err; logic [AW-1:0] ra;
    m0 = mem[0]; m1 = mem[1];
    for (int i = 0; i < 2; i++) begin
      run_req(wr[i], sz[i], 1'b0, adr[i], 32'h1234_5678, lat, rd, err, re_at, we_at, din, ra, viol);
      checks++;
      if (lat !== 1 || err !== 1'b1 || rd !== 32'h0 || re_at !== 0 || we_at !== 0) begin
        errors++; $display("FAIL misaligned[%0d]: got lat=%0d err=%b rdata=%h re_at=%0d we_at=%0d want 1,1,0,0,0",
                           i, lat, err, rd, re_at, we_at);
      end
    end
    @(negedge CLK);
    checks++;
    if (mem[0] !== m0 || mem[1] !== m1) begin
      errors++; $display("FAIL misaligned_ram: got %h %h want %h %h", mem[0], mem[1], m0, m1);
    end
  endtask

  task automatic test_reset_during_wr();
    int w, seen;
    mem[8] = 32'h0102_0304; ref_mem[8] = 32'h0102_0304;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge CLK); w++; end
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    #1;
    checks++;
    if (ram_we !== 1'b1) begin
      errors++; $display("FAIL wr_before_reset: got ram_we=%b want 1", ram_we);
    end
    RESET = 1'b1;
    #1;
    checks++;
    if (ram_we !== 1'b0 || ram_din !== 32'h0) begin
      errors++; $display("FAIL wr_abort: got ram_we=%b din=%h want 0,0", ram_we, ram_din);
    end
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL wr_abort_ready: got %b want 1", req_ready);
    end
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      if (resp_valid) seen++;
    end
    checks++;
    if (seen !== 0 || mem[8] !== 32'h0102_0304) begin
      errors++; $display("FAIL wr_abort_effect: got resp_pulses=%0d ram8=%h want 0,01020304", seen, mem[8]);
    end
  endtask

  task automatic test_wrap();
    int lat, re_at, we_at, viol; logic [31:0] rd, din; logic err; logic [AW-1:0] ra;
    mem[1] = 32'h5A5A_0F0F; ref_mem[1] = 32'h5A5A_0F0F;
    run_req(1'b0, 2'b10, 1'b0, 32'h1004, 32'h0, lat, rd, err, re_at, we_at, din, ra, viol);
    checks++;
    if (ra !== 10'd1 || rd !== 32'h5A5A_0F0F) begin
      errors++; $display("FAIL wrap: got ram_addr=%0d rdata=%h want 1,5a5a0f0f", ra, rd);
    end
  endtask

  task automatic test_back_to_back();
    int r1, r2, rdy, w; logic [31:0] d1, d2;
    mem[3] = 32'hCAFE_F00D; ref_mem[3] = 32'hCAFE_F00D;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge CLK); w++; end
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h0C; req_wdata = 32'h0;
    r1 = 0; r2 = 0; rdy = 0; d1 = 32'h0; d2 = 32'h0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge CLK);
      if (r1 != 0 && !resp_valid && req_ready) rdy++;
      if (resp_valid) begin
        if (r1 == 0) begin r1 = c; d1 = resp_rdata; end
        else begin r2 = c; d2 = resp_rdata; break; end
      end
    end
    req_valid = 1'b0;
    checks++;
    if (r1 !== 2 || r2 - r1 !== 3 || rdy !== 1) begin
      errors++; $display("FAIL back_to_back_timing: got r1=%0d r2=%0d ready_cycles=%0d want 2,5,1",
                         r1, r2, rdy);
    end
    checks++;
    if (d1 !== 32'hCAFE_F00D || d2 !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL back_to_back_data: got %h %h want cafef00d", d1, d2);
    end
  endtask

  task automatic test_random();
    int lat, re_at, we_at, viol, elat, diff;
    logic [31:0] rd, din, er, addr, wd; logic err, eerr, wr, un; logic [1:0] sz;
    logic [AW-1:0] ra;
    for (int i = 0; i < 300; i++) begin
      wr   = 1'($urandom_range(0, 1));
      un   = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      addr = $urandom;
      wd   = $urandom;
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) addr = addr & ~((32'h1 << sz) - 32'h1);
      ref_access(wr, sz, un, addr, wd, eerr, er, elat);
      run_req(wr, sz, un, addr, wd, lat, rd, err, re_at, we_at, din, ra, viol);
      checks++;
      if (lat !== elat || err !== eerr) begin
        errors++; $display("FAIL rand[%0d]_lat_err: got lat=%0d err=%b want %0d,%b (wr=%b sz=%0d addr=%h)",
                           i, lat, err, elat, eerr, wr, sz, addr);
      end
      checks++;
      if (rd !== er) begin
        errors++; $display("FAIL rand[%0d]_rdata: got %h want %h (wr=%b sz=%0d uns=%b addr=%h)",
                           i, rd, er, wr, sz, un, addr);
      end
      checks++;
      if (viol !== 0) begin
        errors++; $display("FAIL rand[%0d]_idle_outputs: got %0d violations want 0", i, viol);
      end
    end
    @(negedge CLK);
    diff = 0;
    for (int i = 0; i < int'(LARGO); i++) if (mem[i] !== ref_mem[i]) diff++;
    checks++;
    if (diff !== 0) begin
      errors++; $display("FAIL rand_ram_contents: got %0d differing words want 0", diff);
    end
  endtask

  initial begin
    for (int i = 0; i < int'(LARGO); i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_load_word();
    test_load_sub();
    test_rmw_store();
    test_errors();
    test_reset_during_wr();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
